// File: rtl/osc_pkg.sv
// Shared oscilloscope definitions: trace-dump FSM states, trace geometry and
// channel select codes.
package osc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WT,
    SEND,
    DONE
  } dump_state_t;

  localparam int unsigned TRACE_ADDR_W = 9;
  localparam int unsigned TRACE_DEPTH  = 512;

  localparam logic [1:0] CH1 = 2'd0;
  localparam logic [1:0] CH2 = 2'd1;
  localparam logic [1:0] CH3 = 2'd2;

endpackage

// File: rtl/trace_dump.sv
// Capture-RAM reader: walks one channel's circular trace from oldest to newest
// sample and streams each byte to the host transmitter over valid/ready.
module trace_dump
  import osc_pkg::*;
#(
  parameter int unsigned ADDR_W = TRACE_ADDR_W,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = TRACE_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        ch_sel,
  input  logic              abort,
  input  logic              cap_done,
  input  logic [ADDR_W-1:0] trace_end,
  input  logic [DATA_W-1:0] rdata_ch1,
  input  logic [DATA_W-1:0] rdata_ch2,
  input  logic [DATA_W-1:0] rdata_ch3,
  input  logic              tx_rdy,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_vld,
  output logic              dump_busy,
  output logic              dump_done,
  output logic              clr_cap_done,
  output logic              nak
);

  localparam int unsigned   CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        ch_q;
  logic [DATA_W-1:0] tx_data_q;
  logic [DATA_W-1:0] rdata_sel;
  logic              nak_q;
  logic              req_ok;
  logic              accept;
  logic              advance;

  assign req_ok  = cap_done && (ch_sel != 2'd3);
  assign accept  = (state_q == IDLE) && start && req_ok;
  // abort outranks a same-cycle handshake, so the byte is not consumed
  assign advance = (state_q == SEND) && tx_rdy && !abort;

  always_comb begin
    rdata_sel = '0;
    case (ch_q)
      CH1:     rdata_sel = rdata_ch1;
      CH2:     rdata_sel = rdata_ch2;
      CH3:     rdata_sel = rdata_ch3;
      default: rdata_sel = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RD;
      RD:      state_d = WT;
      WT:      state_d = SEND;
      SEND:    if (tx_rdy) state_d = (cnt_q == LAST_CNT) ? DONE : RD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) state_d = IDLE;
  end

  always_comb begin
    ram_en       = 1'b0;
    tx_vld       = 1'b0;
    dump_busy    = 1'b1;
    dump_done    = 1'b0;
    clr_cap_done = 1'b0;
    case (state_q)
      IDLE:    dump_busy = 1'b0;
      RD:      ram_en = 1'b1;
      SEND:    tx_vld = 1'b1;
      DONE: begin
        dump_done    = 1'b1;
        clr_cap_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      ch_q      <= '0;
      tx_data_q <= '0;
      nak_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      nak_q   <= (state_q == IDLE) && start && !req_ok;
      if (accept) begin
        ch_q  <= ch_sel;
        ptr_q <= trace_end + ADDR_W'(1);
        cnt_q <= '0;
      end
      if (state_q == WT) tx_data_q <= rdata_sel;
      if (advance) begin
        ptr_q <= ptr_q + ADDR_W'(1);
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign ram_addr = ptr_q;
  assign tx_data  = tx_data_q;
  assign nak      = nak_q;

endmodule

// File: tb/tb_trace_dump.sv
// Self-checking bench for trace_dump: reject table, directed full/wrap/stall/
// abort/reset dumps and randomized dumps against an expected-sequence model.
module tb_trace_dump;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 8;
  localparam int          DEPTH  = 512;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [1:0]        ch_sel = '0;
  logic              abort = 1'b0;
  logic              cap_done = 1'b0;
  logic [ADDR_W-1:0] trace_end = '0;
  logic [DATA_W-1:0] rdata_ch1 = '0;
  logic [DATA_W-1:0] rdata_ch2 = '0;
  logic [DATA_W-1:0] rdata_ch3 = '0;
  logic              tx_rdy = 1'b0;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] tx_data;
  logic              tx_vld;
  logic              dump_busy;
  logic              dump_done;
  logic              clr_cap_done;
  logic              nak;

  trace_dump #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .ch_sel(ch_sel), .abort(abort),
    .cap_done(cap_done), .trace_end(trace_end),
    .rdata_ch1(rdata_ch1), .rdata_ch2(rdata_ch2), .rdata_ch3(rdata_ch3),
    .tx_rdy(tx_rdy), .ram_en(ram_en), .ram_addr(ram_addr), .tx_data(tx_data),
    .tx_vld(tx_vld), .dump_busy(dump_busy), .dump_done(dump_done),
    .clr_cap_done(clr_cap_done), .nak(nak)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Per-channel RAM contents; channels differ so a wrong mux select shows up.
  function automatic logic [7:0] mem(int ch, int a);
    logic [7:0] b;
    b = a[7:0];
    case (ch)
      0:       return b + 8'h40;
      1:       return b;
      default: return ~b;
    endcase
  endfunction

  always @(posedge clk) begin
    if (ram_en) begin
      rdata_ch1 <= mem(0, int'(ram_addr));
      rdata_ch2 <= mem(1, int'(ram_addr));
      rdata_ch3 <= mem(2, int'(ram_addr));
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] got_q[$];
  int         addr_q[$];
  int first_vld, last_hs, done_cyc, done_cnt, clr_cnt, coin_err, nak_cnt, stall_err;
  logic prev_vld = 1'b0, prev_rdy = 1'b0, prev_abort = 1'b0, prev_rst = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    if (tx_vld && tx_rdy && !abort && !rst) begin
      got_q.push_back(tx_data);
      last_hs = cyc;
    end
    if (ram_en) addr_q.push_back(int'(ram_addr));
    if (tx_vld && first_vld < 0) first_vld = cyc;
    if (dump_done) begin done_cnt++; done_cyc = cyc; end
    if (clr_cap_done) clr_cnt++;
    if (dump_done != clr_cap_done) coin_err++;
    if (nak) nak_cnt++;
    if (prev_vld && !prev_rdy && !prev_abort && !prev_rst)
      if (!tx_vld || tx_data != prev_data) stall_err++;
    prev_vld = tx_vld; prev_rdy = tx_rdy; prev_abort = abort;
    prev_rst = rst; prev_data = tx_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clr_mon();
    got_q.delete();
    addr_q.delete();
    first_vld = -1; last_hs = 0; done_cyc = 0; done_cnt = 0; clr_cnt = 0;
    coin_err = 0; nak_cnt = 0; stall_err = 0;
  endtask

  task automatic check_zero(string tag);
    check({tag, "_ram_en"}, ram_en, 0);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_tx_vld"}, tx_vld, 0);
    check({tag, "_busy"}, dump_busy, 0);
    check({tag, "_done"}, dump_done, 0);
    check({tag, "_clr"}, clr_cap_done, 0);
    check({tag, "_nak"}, nak, 0);
  endtask

  // Compares the first n received bytes (and reads if chk_addr) with the model.
  task automatic cmp_seq(string tag, int ch, int te, int n, bit chk_addr);
    int bad = 0;
    int first = -1;
    for (int k = 0; k < n && k < got_q.size(); k++) begin
      if (got_q[k] != mem(ch, (te + 1 + k) % DEPTH)) begin
        bad++;
        if (first < 0) first = k;
      end
    end
    check($sformatf("%s_bytes(first bad %0d)", tag, first), bad, 0);
    if (chk_addr) begin
      bad = 0; first = -1;
      for (int k = 0; k < n && k < addr_q.size(); k++) begin
        if (addr_q[k] != (te + 1 + k) % DEPTH) begin
          bad++;
          if (first < 0) first = k;
        end
      end
      check($sformatf("%s_addrs(first bad %0d)", tag, first), bad, 0);
      check({tag, "_n_reads"}, addr_q.size(), n);
    end
  endtask

  // kill_at >= 0: after kill_at bytes, assert abort (or rst if kill_rst) in SEND.
  task automatic run_dump(input int ch, input int te, input int rdy_pct,
                          input int stall_at, input int stall_len,
                          input int kill_at, input bit kill_rst,
                          input bit disturb, input bit abort_w_start,
                          output int start_cyc, output int stalled);
    int n = 0;
    bit dist_done = 0;
    stalled = 0;
    clr_mon();
    trace_end = ADDR_W'(te); ch_sel = 2'(ch); cap_done = 1'b1; start = 1'b1;
    abort = abort_w_start;
    start_cyc = cyc;
    step();
    start = 1'b0; abort = 1'b0;
    while (done_cnt == 0 && n < 8000) begin
      tx_rdy = ($urandom_range(99) < rdy_pct);
      start = 1'b0;
      if (stall_at >= 0 && got_q.size() == stall_at && tx_vld && stalled < stall_len) begin
        tx_rdy = 1'b0;
        stalled++;
      end
      if (disturb && !dist_done && got_q.size() == 200) begin
        start = 1'b1; ch_sel = 2'd3; cap_done = 1'b0; trace_end = ADDR_W'($urandom);
        dist_done = 1;
      end
      if (kill_at >= 0 && got_q.size() == kill_at && tx_vld) begin
        if (kill_rst) begin rst = 1'b1; tx_rdy = 1'b0; end
        else begin abort = 1'b1; tx_rdy = 1'b1; end
        step();
        break;
      end
      step();
      n++;
    end
    check("dump_timeout", n >= 8000, 0);
    start = 1'b0; tx_rdy = 1'b0; cap_done = 1'b1;
  endtask

  task automatic verify_full(string tag, int ch, int te, int start_cyc, int exp_cycles);
    int lat;
    int fin;
    check({tag, "_busy_after"}, dump_busy, 0);
    lat = first_vld - start_cyc;
    fin = done_cyc - start_cyc;
    repeat (3) step();
    check({tag, "_n_bytes"}, got_q.size(), DEPTH);
    cmp_seq(tag, ch, te, DEPTH, 1);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_clr_pulses"}, clr_cnt, 1);
    check({tag, "_pulse_align"}, coin_err, 0);
    check({tag, "_first_vld_lat"}, lat, 3);
    check({tag, "_done_after_hs"}, done_cyc - last_hs, 1);
    check({tag, "_nak_during"}, nak_cnt, 0);
    check({tag, "_stall_stable"}, stall_err, 0);
    if (exp_cycles >= 0) check({tag, "_dump_cycles"}, fin, exp_cycles);
  endtask

  typedef struct {
    logic       st;
    logic [1:0] ch;
    logic       cap;
    logic       exp_nak;
  } rej_vec_t;

  initial begin
    rej_vec_t vecs[6];
    int sc, stl, ch, te;

    vecs[0] = '{1'b1, 2'd1, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 2'd3, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 2'd3, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 2'd1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 2'd0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 2'd3, 1'b1, 1'b0};

    rst = 1'b1;
    repeat (3) step();
    check_zero("reset");
    rst = 1'b0;
    step();
    clr_mon();

    foreach (vecs[i]) begin
      start = vecs[i].st; ch_sel = vecs[i].ch; cap_done = vecs[i].cap;
      step();
      start = 1'b0; cap_done = 1'b0;
      check($sformatf("rej%0d_nak", i), nak, vecs[i].exp_nak);
      check($sformatf("rej%0d_busy", i), dump_busy, 0);
      step();
      check($sformatf("rej%0d_nak_clear", i), nak, 0);
      check($sformatf("rej%0d_busy2", i), dump_busy, 0);
    end

    run_dump(1, 9, 100, -1, 0, -1, 0, 0, 0, sc, stl);
    verify_full("full", 1, 9, sc, 3 * DEPTH + 1);

    run_dump(0, 511, 100, -1, 0, -1, 0, 0, 0, sc, stl);
    check("wrap_first_addr", addr_q.size() > 0 ? addr_q[0] : -1, 0);
    check("wrap_last_addr", addr_q.size() == DEPTH ? addr_q[DEPTH-1] : -1, 511);
    verify_full("wrap", 0, 511, sc, 3 * DEPTH + 1);

    run_dump(2, 300, 100, 37, 5, -1, 0, 0, 0, sc, stl);
    check("stall_cycles_applied", stl, 5);
    verify_full("stall", 2, 300, sc, 3 * DEPTH + 1 + 5);

    run_dump(1, 9, 100, -1, 0, 101, 0, 0, 0, sc, stl);
    abort = 1'b0;
    check("abort_busy", dump_busy, 0);
    check("abort_vld", tx_vld, 0);
    repeat (4) step();
    check("abort_n_bytes", got_q.size(), 101);
    cmp_seq("abort", 1, 9, 101, 0);
    check("abort_done", done_cnt, 0);
    check("abort_clr", clr_cnt, 0);
    run_dump(1, 9, 100, -1, 0, -1, 0, 0, 0, sc, stl);
    verify_full("retry", 1, 9, sc, 3 * DEPTH + 1);

    run_dump(0, 100, 100, -1, 0, 50, 1, 0, 0, sc, stl);
    check_zero("midrst");
    rst = 1'b0;
    step();
    check("midrst_n_bytes", got_q.size(), 50);
    run_dump(0, 100, 100, -1, 0, -1, 0, 0, 0, sc, stl);
    verify_full("postrst", 0, 100, sc, 3 * DEPTH + 1);

    for (int r = 0; r < 3; r++) begin
      ch = $urandom_range(2);
      te = $urandom_range(DEPTH - 1);
      run_dump(ch, te, $urandom_range(60, 90), -1, 0, -1, 0, 1, r == 0, sc, stl);
      verify_full($sformatf("rand%0d", r), ch, te, sc, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
